// File: rtl/vreg_pkg.sv
// rtl/vreg_pkg.sv - shared widths and FSM state type for the vector register port scheduler
package vreg_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 256;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/vreg_rr_arb2.sv
// rtl/vreg_rr_arb2.sv - two-way round-robin arbiter, pointer advances only on a grant
module vreg_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    // Set when requester 1 was granted last, so requester 0 wins the next tie.
    logic r_last;

    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (|o_grant) begin
            r_last <= o_grant[1];
        end
    end

endmodule

// File: rtl/vreg_port_sched.sv
// rtl/vreg_port_sched.sv - vector regfile port scheduler; VREG_BYPASS_EN selects hazard forwarding instead of read stall
module vreg_port_sched
    import vreg_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              Vreset,
    input  logic              start,
    input  logic              finish,
    output logic              busy,
    output logic              done,
    input  logic              wr0_valid,
    output logic              wr0_ready,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_valid,
    output logic              wr1_ready,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              rd_resp_valid,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [ADDR_W-1:0] VreadA,
    output logic [ADDR_W-1:0] VreadB,
    output logic [ADDR_W-1:0] VwrAddr,
    output logic [DATA_W-1:0] Vwrdata,
    output logic              VwrEn,
    output logic              Vstart,
    input  logic [DATA_W-1:0] Va,
    input  logic [DATA_W-1:0] Vb
);

    state_t r_state;
    logic   r_busy;
    logic   r_done;
    logic   r_resp_valid;

    logic [1:0] w_req;
    logic [1:0] w_grant;
    logic       w_fire;
    logic       w_run;
    logic       w_hit_a;
    logic       w_hit_b;
    logic       w_rd_fire;

    // Writes are only offered to the arbiter while the write window is open.
    assign w_req = {wr1_valid, wr0_valid} & {2{r_busy}};

    vreg_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (Vreset),
        .i_valid (w_req),
        .o_grant (w_grant)
    );

    assign wr0_ready = w_grant[0];
    assign wr1_ready = w_grant[1];
    assign w_fire    = |w_grant;
    assign VwrEn     = w_fire;
    assign VwrAddr   = w_grant[0] ? wr0_addr : (w_grant[1] ? wr1_addr : '0);
    assign Vwrdata   = w_grant[0] ? wr0_data : (w_grant[1] ? wr1_data : '0);

    assign VreadA = rd_addr_a;
    assign VreadB = rd_addr_b;

    assign w_run   = (r_state == S_RUN);
    assign w_hit_a = w_fire && (VwrAddr == rd_addr_a);
    assign w_hit_b = w_fire && (VwrAddr == rd_addr_b);

`ifdef VREG_BYPASS_EN
    assign rd_ready = w_run;
`else
    assign rd_ready = w_run && !(rd_valid && (w_hit_a || w_hit_b));
`endif

    assign w_rd_fire = rd_valid && rd_ready;

    always_ff @(posedge clk) begin
        if (Vreset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (finish) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!wr0_valid && !wr1_valid) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign Vstart = r_busy;
    assign done   = r_done;

    always_ff @(posedge clk) begin
        if (Vreset) begin
            r_resp_valid <= 1'b0;
        end else begin
            r_resp_valid <= w_rd_fire;
        end
    end

    assign rd_resp_valid = r_resp_valid;

`ifdef VREG_BYPASS_EN
    logic              r_byp_a;
    logic              r_byp_b;
    logic [DATA_W-1:0] r_byp_data;

    // The regfile returns the pre-write value on a same-cycle hit, so forward the write data.
    always_ff @(posedge clk) begin
        if (Vreset) begin
            r_byp_a    <= 1'b0;
            r_byp_b    <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_byp_a    <= w_rd_fire && w_hit_a;
            r_byp_b    <= w_rd_fire && w_hit_b;
            r_byp_data <= Vwrdata;
        end
    end

    assign rd_data_a = r_resp_valid ? (r_byp_a ? r_byp_data : Va) : '0;
    assign rd_data_b = r_resp_valid ? (r_byp_b ? r_byp_data : Vb) : '0;
`else
    assign rd_data_a = r_resp_valid ? Va : '0;
    assign rd_data_b = r_resp_valid ? Vb : '0;
`endif

endmodule

// File: tb/tb_vreg_port_sched.sv
// tb/tb_vreg_port_sched.sv - directed bench with read scoreboard and regfile model for vreg_port_sched
module tb_vreg_port_sched;

    localparam int AW = 3;
    localparam int DW = 256;

    logic          clk;
    logic          Vreset;
    logic          start;
    logic          finish;
    logic          busy;
    logic          done;
    logic          wr0_valid;
    logic          wr0_ready;
    logic [AW-1:0] wr0_addr;
    logic [DW-1:0] wr0_data;
    logic          wr1_valid;
    logic          wr1_ready;
    logic [AW-1:0] wr1_addr;
    logic [DW-1:0] wr1_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          rd_resp_valid;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic [AW-1:0] VreadA;
    logic [AW-1:0] VreadB;
    logic [AW-1:0] VwrAddr;
    logic [DW-1:0] Vwrdata;
    logic          VwrEn;
    logic          Vstart;
    logic [DW-1:0] Va;
    logic [DW-1:0] Vb;

    int checks;
    int failures;
    int done_cnt;

    logic [DW-1:0]   mem     [0:7];
    logic [DW-1:0]   exp_mem [0:7];
    logic [2*DW-1:0] exp_q   [$];

    vreg_port_sched #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .Vreset        (Vreset),
        .start         (start),
        .finish        (finish),
        .busy          (busy),
        .done          (done),
        .wr0_valid     (wr0_valid),
        .wr0_ready     (wr0_ready),
        .wr0_addr      (wr0_addr),
        .wr0_data      (wr0_data),
        .wr1_valid     (wr1_valid),
        .wr1_ready     (wr1_ready),
        .wr1_addr      (wr1_addr),
        .wr1_data      (wr1_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr_a     (rd_addr_a),
        .rd_addr_b     (rd_addr_b),
        .rd_resp_valid (rd_resp_valid),
        .rd_data_a     (rd_data_a),
        .rd_data_b     (rd_data_b),
        .VreadA        (VreadA),
        .VreadB        (VreadB),
        .VwrAddr       (VwrAddr),
        .Vwrdata       (Vwrdata),
        .VwrEn         (VwrEn),
        .Vstart        (Vstart),
        .Va            (Va),
        .Vb            (Vb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file with registered read returning the pre-write value on a collision.
    always @(posedge clk) begin
        if (VwrEn) mem[VwrAddr] <= Vwrdata;
        Va <= mem[VreadA];
        Vb <= mem[VreadB];
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Scoreboard: push expected operands on read accept, pop on response.
    always @(negedge clk) begin : mon
        logic [2*DW-1:0] e;
        logic [DW-1:0]   ea;
        logic [DW-1:0]   eb;
        logic            fv;
        logic [AW-1:0]   fa;
        logic [DW-1:0]   fd;
        if (rd_resp_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL resp_unexpected observed_resp=%0b expected_resp=0", rd_resp_valid);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_rd_data_a", rd_data_a, e[2*DW-1:DW]);
                chk("sb_rd_data_b", rd_data_b, e[DW-1:0]);
            end
        end
        fv = (wr0_valid && wr0_ready) || (wr1_valid && wr1_ready);
        fa = (wr0_valid && wr0_ready) ? wr0_addr : wr1_addr;
        fd = (wr0_valid && wr0_ready) ? wr0_data : wr1_data;
        if (Vreset) begin
            exp_q.delete();
        end else if (rd_valid && rd_ready) begin
            ea = exp_mem[rd_addr_a];
            eb = exp_mem[rd_addr_b];
`ifdef VREG_BYPASS_EN
            if (fv && fa == rd_addr_a) ea = fd;
            if (fv && fa == rd_addr_b) eb = fd;
`endif
            exp_q.push_back({ea, eb});
        end
        if (fv) exp_mem[fa] = fd;
        if (done) done_cnt++;
    end

    initial begin
        checks = 0; failures = 0; done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            mem[i] = '0;
            exp_mem[i] = '0;
        end
        Va = '0; Vb = '0;
        Vreset = 1'b1; start = 1'b0; finish = 1'b0;
        wr0_valid = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_valid = 1'b0; wr1_addr = '0; wr1_data = '0;
        rd_valid = 1'b0; rd_addr_a = '0; rd_addr_b = '0;

        settle();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vstart", Vstart, 0);
        chk("rst_vwren", VwrEn, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_resp_valid", rd_resp_valid, 0);
        chk("rst_rd_data_a", rd_data_a, 0);
        tick(); tick();

        // 1: write R3 then read it back
        Vreset = 1'b0; start = 1'b1;
        settle(); chk("t1_idle_busy", busy, 0); tick();
        start = 1'b0;
        settle(); chk("t1_busy", busy, 1); chk("t1_vstart", Vstart, 1); tick();
        wr0_valid = 1'b1; wr0_addr = 3'd3; wr0_data = {32{8'hA5}};
        settle();
        chk("t1_wr0_ready", wr0_ready, 1);
        chk("t1_vwren", VwrEn, 1);
        chk("t1_vwraddr", VwrAddr, 3);
        tick();
        wr0_valid = 1'b0; rd_valid = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd0;
        settle(); chk("t1_rd_ready", rd_ready, 1); tick();
        rd_valid = 1'b0;
        settle();
        chk("t1_resp_valid", rd_resp_valid, 1);
        chk("t1_rd_data_a", rd_data_a, {32{8'hA5}});
        tick();

        // 2: both writers contend; wr0 was granted last so wr1 goes first
        for (int i = 0; i < 4; i++) begin
            wr0_valid = 1'b1; wr0_addr = 3'd1; wr0_data = {8{32'(i)}};
            wr1_valid = 1'b1; wr1_addr = 3'd2; wr1_data = {8{32'(i + 100)}};
            settle();
            chk("t2_wr1_ready", wr1_ready, ((i % 2) == 0) ? 1 : 0);
            chk("t2_wr0_ready", wr0_ready, ((i % 2) == 0) ? 0 : 1);
            chk("t2_vwren", VwrEn, 1);
            chk("t2_vwraddr", VwrAddr, ((i % 2) == 0) ? 2 : 1);
            tick();
        end
        wr0_valid = 1'b0; wr1_valid = 1'b0;

        // 3: same-cycle write and read of R5
        wr0_valid = 1'b1; wr0_addr = 3'd5; wr0_data = {32{8'h11}};
        rd_valid = 1'b1; rd_addr_a = 3'd5; rd_addr_b = 3'd3;
        settle();
        chk("t3_vwren", VwrEn, 1);
`ifdef VREG_BYPASS_EN
        chk("t3_rd_ready_byp", rd_ready, 1);
        tick();
        wr0_valid = 1'b0; rd_valid = 1'b0;
`else
        chk("t3_rd_ready_stall", rd_ready, 0);
        tick();
        wr0_valid = 1'b0;
        settle(); chk("t3_rd_ready_retry", rd_ready, 1); tick();
        rd_valid = 1'b0;
`endif
        settle();
        chk("t3_resp_valid", rd_resp_valid, 1);
        chk("t3_rd_data_a", rd_data_a, {32{8'h11}});
        tick();

        // write and read to different registers proceed together
        wr1_valid = 1'b1; wr1_addr = 3'd6; wr1_data = {32{8'h22}};
        rd_valid = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd2;
        settle();
        chk("t3b_rd_ready", rd_ready, 1);
        chk("t3b_wr1_ready", wr1_ready, 1);
        tick();
        wr1_valid = 1'b0; rd_valid = 1'b0;
        settle(); chk("t3b_rd_data_b", rd_data_b, {8{32'd102}}); tick();

        // 4: finish, two drain writes, then done
        finish = 1'b1;
        settle(); tick();
        finish = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wr1_valid = 1'b1; wr1_addr = 3'd7; wr1_data = {8{32'(i + 7)}};
            rd_valid = 1'b1; rd_addr_a = 3'd0; rd_addr_b = 3'd1;
            settle();
            chk("t4_drain_wr1_ready", wr1_ready, 1);
            chk("t4_drain_rd_ready", rd_ready, 0);
            chk("t4_drain_busy", busy, 1);
            tick();
        end
        wr1_valid = 1'b0; rd_valid = 1'b0;
        settle(); chk("t4_last_drain_done", done, 0); chk("t4_last_drain_busy", busy, 1); tick();
        settle(); chk("t4_done_pulse", done, 1); chk("t4_busy_low", busy, 0); tick();
        settle(); chk("t4_done_clear", done, 0); tick();

        // 5: IDLE blocks writes and reads
        wr0_valid = 1'b1; wr0_addr = 3'd4; wr0_data = {32{8'h33}};
        rd_valid = 1'b1; rd_addr_a = 3'd4; rd_addr_b = 3'd4;
        settle();
        chk("t5_wr0_ready", wr0_ready, 0);
        chk("t5_rd_ready", rd_ready, 0);
        chk("t5_vwren", VwrEn, 0);
        chk("t5_vstart", Vstart, 0);
        chk("t5_vwraddr", VwrAddr, 0);
        tick();
        wr0_valid = 1'b0; rd_valid = 1'b0; start = 1'b1; finish = 1'b1;
        settle(); tick();
        start = 1'b0; finish = 1'b0;
        settle(); chk("t5_start_wins_busy", busy, 1); chk("t5_in_run", rd_ready, 1); tick();

        // 6: reset mid-session with a read being accepted
        rd_valid = 1'b1; rd_addr_a = 3'd6; rd_addr_b = 3'd5; Vreset = 1'b1;
        settle(); tick();
        Vreset = 1'b0; rd_valid = 1'b0;
        settle();
        chk("t6_busy", busy, 0);
        chk("t6_vstart", Vstart, 0);
        chk("t6_resp_valid", rd_resp_valid, 0);
        chk("t6_rd_data_a", rd_data_a, 0);
        chk("t6_done", done, 0);
        tick();
        settle(); chk("t6_done_later", done, 0); tick();

        // arbiter pointer back to wr0-preferred after reset
        start = 1'b1;
        settle(); tick();
        start = 1'b0; wr0_valid = 1'b1; wr1_valid = 1'b1;
        wr0_addr = 3'd0; wr0_data = {32{8'h44}}; wr1_addr = 3'd1; wr1_data = {32{8'h55}};
        settle(); chk("t6_rr_reset_wr0", wr0_ready, 1); chk("t6_rr_reset_wr1", wr1_ready, 0); tick();
        wr0_valid = 1'b0; wr1_valid = 1'b0;
        settle(); tick();

        chk("done_pulse_count", done_cnt, 1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
